// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and width helpers for the SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int beats_of(input int data_w, input int sram_dw);
    return data_w / sram_dw;
  endfunction

  // Index width for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - CPU-side word access port of the SRAM controller.
interface sram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  wrEn;
  logic                  rdEn;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wrData;
  logic [DATA_W/8-1:0]   byteEn;
  logic [DATA_W-1:0]     rdData;
  logic                  ready;

  modport master (output wrEn, rdEn, addr, wrData, byteEn, input rdData, ready);
  modport slave  (input wrEn, rdEn, addr, wrData, byteEn, output rdData, ready);
endinterface

// File: rtl/sram_addr_map.sv
// rtl/sram_addr_map.sv - CPU byte address plus beat index to SRAM word address.
module sram_addr_map #(
  parameter int DATA_W    = 32,
  parameter int SRAM_DW   = 16,
  parameter int ADDR_W    = 32,
  parameter int SRAM_AW   = 18,
  parameter int BASE_ADDR = 1024,
  parameter int BEAT_W    = 1
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BEAT_W-1:0]  beat,
  output logic [SRAM_AW-1:0] sram_addr
);
  localparam int BEATS = DATA_W / SRAM_DW;
  localparam int SHIFT = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;

  // Addresses below the base wrap modulo the SRAM depth rather than faulting.
  always_comb begin
    offset    = addr - ADDR_W'(BASE_ADDR);
    word      = offset >> SHIFT;
    sram_addr = SRAM_AW'(word) * SRAM_AW'(BEATS) + SRAM_AW'(beat);
  end
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - splits a CPU word access into timed SRAM beats and stalls via ready.
// Optional byte-lane writes: define SRAM_CTRL_BYTE_EN_EN.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int ADDR_W      = 32,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         cpu,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);
  localparam int BEATS  = beats_of(DATA_W, SRAM_DW);
  localparam int LANES  = SRAM_DW / 8;
  localparam int BEAT_W = idx_width(BEATS);
  localparam int CNT_W  = idx_width(WAIT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                request, last_cnt, last_beat, lanes_on, dq_oe;
  logic [SRAM_AW-1:0]  map_addr;
  logic [SRAM_DW-1:0]  dq_out;
  logic [LANES-1:0]    lane_en;

  sram_addr_map #(
    .DATA_W(DATA_W), .SRAM_DW(SRAM_DW), .ADDR_W(ADDR_W),
    .SRAM_AW(SRAM_AW), .BASE_ADDR(BASE_ADDR), .BEAT_W(BEAT_W)
  ) u_addr_map (
    .addr     (addr_q),
    .beat     (beat_q),
    .sram_addr(map_addr)
  );

  assign request   = cpu.wrEn | cpu.rdEn;
  assign last_cnt  = (cnt_q == CNT_W'(WAIT_CYCLES));
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign dq_out    = wdata_q[int'(beat_q)*SRAM_DW +: SRAM_DW];
  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign cpu.rdData = rdata_q;

`ifdef SRAM_CTRL_BYTE_EN_EN
  logic [DATA_W/8-1:0] ben_q, ben_d;
  assign ben_d   = (state_q == IDLE && request) ? cpu.byteEn : ben_q;
  assign lane_en = ben_q[int'(beat_q)*LANES +: LANES];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ben_q <= '0;
    else     ben_q <= ben_d;
  end
`else
  logic unused_byte_en;
  assign unused_byte_en = ^cpu.byteEn;
  assign lane_en        = '1;
`endif
  assign lanes_on = |lane_en;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cpu.ready = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b0;
    SRAM_LB_N = 1'b0;
    dq_oe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu.ready = ~request;
        if (request) begin
          state_d = ACCESS;
          beat_d  = '0;
          cnt_d   = '0;
          wr_d    = cpu.wrEn;
          addr_d  = cpu.addr;
          wdata_d = cpu.wrData;
        end
      end
      ACCESS: begin
        SRAM_ADDR = map_addr;
        if (wr_q) begin
          dq_oe     = 1'b1;
          // Strobe released on the final cycle so address and data hold past WE_N rise.
          SRAM_WE_N = ~(lanes_on && !last_cnt);
`ifdef SRAM_CTRL_BYTE_EN_EN
          SRAM_LB_N = ~lane_en[0];
          SRAM_UB_N = ~lane_en[LANES-1];
`endif
        end
        if (last_cnt) begin
          cnt_d = '0;
          if (!wr_q) rdata_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          if (last_beat) state_d = DONE;
          else           beat_d  = beat_q + BEAT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cpu.ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl (default and WAIT_CYCLES=3 instances).
module tb_sram_ctrl;
  localparam int W = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  sram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) cif ();
  logic [17:0] sram_addr;
  logic        we_n, ub_n, lb_n, ce_n, oe_n;
  wire  [15:0] dq;
  logic        rd_drive = 1'b0;
  logic [15:0] mem [0:262143];

  sram_ctrl dut (
    .clk(clk), .rst(rst), .cpu(cif),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(dq), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  assign dq = rd_drive ? mem[sram_addr] : 16'bz;
  always @(posedge clk) begin
    if (!we_n) begin
      if (!lb_n) mem[sram_addr][7:0]  <= dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] <= dq[15:8];
    end
  end

  sram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) cif3 ();
  logic [17:0] sram_addr3;
  logic        we3_n, ub3_n, lb3_n, ce3_n, oe3_n;
  wire  [15:0] dq3;
  logic        rd3_drive = 1'b0;

  sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cpu(cif3),
    .SRAM_ADDR(sram_addr3), .SRAM_DQ(dq3), .SRAM_WE_N(we3_n),
    .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n), .SRAM_CE_N(ce3_n), .SRAM_OE_N(oe3_n)
  );
  assign dq3 = rd3_drive ? (16'(sram_addr3) * 16'd7 + 16'd3) : 16'bz;

  // Reference model: expected SRAM contents and the last completed read.
  logic [15:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;

  function automatic logic [15:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 16'h0;
  endfunction

  function automatic logic [17:0] word_of(input logic [31:0] a, input int k);
    logic [31:0] w;
    w = ((a - 32'd1024) / 4) * 2 + k;
    return w[17:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input string tag, output logic [31:0] rd_out);
    int cyc, k, bt, c;
    bit ok_a, ok_w, ok_l, do_wr;
    logic [3:0] mask;
    logic [1:0] lanes;
    logic [15:0] w;
    do_wr = wr;
`ifdef SRAM_CTRL_BYTE_EN_EN
    mask = be;
`else
    mask = 4'hF;
`endif
    @(negedge clk);
    cif.wrEn = wr; cif.rdEn = rd; cif.addr = a; cif.wrData = d; cif.byteEn = be;
    rd_drive = !do_wr;
    cyc = 0; ok_a = 1; ok_w = 1; ok_l = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cif.ready) break;
      k = cyc - 1; bt = k / (W + 1); c = k % (W + 1);
      lanes = mask[2*bt +: 2];
      if (sram_addr !== word_of(a, bt)) ok_a = 0;
      if (we_n !== ((do_wr && c < W && lanes != 2'b00) ? 1'b0 : 1'b1)) ok_w = 0;
      if ({ub_n, lb_n} !== (do_wr ? ~lanes : 2'b00)) ok_l = 0;
    end
    check({tag, "_ready_cycle"}, cyc, 2 * (W + 1) + 1);
    check({tag, "_addr_seq"}, ok_a, 1);
    check({tag, "_we_seq"}, ok_w, 1);
    check({tag, "_lanes"}, ok_l, 1);
    if (do_wr) begin
      for (int b = 0; b < 2; b++) begin
        w = ref_rd(int'(word_of(a, b)));
        for (int l = 0; l < 2; l++)
          if (mask[2*b + l]) w[8*l +: 8] = d[16*b + 8*l +: 8];
        ref_mem[int'(word_of(a, b))] = w;
      end
    end else begin
      last_rd = {ref_rd(int'(word_of(a, 1))), ref_rd(int'(word_of(a, 0)))};
    end
    check({tag, "_rdData"}, cif.rdData, last_rd);
    rd_out = cif.rdData;
    cif.wrEn = 0; cif.rdEn = 0;
    rd_drive = 0;
    if (do_wr)
      check({tag, "_sram_words"}, {mem[word_of(a, 1)], mem[word_of(a, 0)]},
            {ref_rd(int'(word_of(a, 1))), ref_rd(int'(word_of(a, 0)))});
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] got;
    int cyc;
    bit ok3;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    cif.wrEn = 0; cif.rdEn = 0; cif.addr = 0; cif.wrData = 0; cif.byteEn = 0;
    cif3.wrEn = 0; cif3.rdEn = 0; cif3.addr = 0; cif3.wrData = 0; cif3.byteEn = 0;
    tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 4'hF, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,        4'hF, 32'h12345678};
    tbl[4] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 4'hF, 32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 32'd1020, 32'h0,        4'hF, 32'hCAFEF00D};

    #1;
    check("rst_ready", cif.ready, 1);
    check("rst_we_n", we_n, 1);
    check("rst_lanes", {ub_n, lb_n}, 2'b00);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_rdData", cif.rdData, 0);
    check("ce_oe_tied", {ce_n, oe_n, ce3_n, oe3_n}, 4'b0);
    @(negedge clk); rst = 0;

    // Reset during the strobe cycle of a write aborts at once.
    @(negedge clk);
    cif.wrEn = 1; cif.addr = 32'd1024; cif.wrData = 32'h11112222; cif.byteEn = 4'hF;
    @(posedge clk); @(negedge clk);
    check("midwr_we_low", we_n, 0);
    cif.wrEn = 0; rst = 1;
    #1;
    check("midwr_rst_we_n", we_n, 1);
    check("midwr_rst_ready", cif.ready, 1);
    check("midwr_rst_addr", sram_addr, 0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 6; i++) begin
      access(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].be, $sformatf("tbl%0d", i), got);
      check($sformatf("tbl%0d_exp_rd", i), got, tbl[i].exp_rd);
    end
    check("wrap_low_word", mem[262142], 16'hF00D);
    check("wrap_high_word", mem[262143], 16'hCAFE);

`ifdef SRAM_CTRL_BYTE_EN_EN
    access(1, 0, 32'd1024, 32'h0, 4'hF, "be_clear", got);
    access(1, 0, 32'd1024, 32'hAABBCCDD, 4'b0010, "be_write", got);
    access(0, 1, 32'd1024, 32'h0, 4'hF, "be_read", got);
    check("be_readback", got, 32'h0000CC00);
`endif

    for (int i = 0; i < 40; i++) begin
      bit wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      access(wr, rd, 32'd1020 + 4 * $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
             $sformatf("rnd%0d", i), got);
    end

    // Longer beats: each word address held for WAIT_CYCLES+1 = 4 cycles.
    @(negedge clk);
    cif3.rdEn = 1; cif3.addr = 32'd1032; rd3_drive = 1;
    cyc = 0; ok3 = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cif3.ready) break;
      if (sram_addr3 !== ((cyc <= 4) ? 18'd4 : 18'd5)) ok3 = 0;
      if (we3_n !== 1'b1) ok3 = 0;
    end
    check("w3_ready_cycle", cyc, 9);
    check("w3_addr_we_seq", ok3, 1);
    check("w3_rdData", cif3.rdData, 32'h0026001F);
    cif3.rdEn = 0; rd3_drive = 0;
    @(negedge clk);
    check("w3_idle_ready", cif3.ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
